pipe_stage_skid: RTL

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 97 +++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage (main=head, skid). An entry accepted into an empty stage appears on out_* one cycle later.
// Backpressure: in_ready is decoded from registered state only, and is low only when both entries are full.
module pipe_stage_skid #(
    parameter int                 INSTR_W      = 32,
    parameter int                 PC_W         = 32,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(32'hFC00_0000),
    parameter int                 CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pcplus4,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pcplus4,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pcplus4;
    } entry_t;

    state_t           state_q;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           in_ent;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             accept;
    logic             drain;

    assign in_ent = {in_instr, in_pcplus4};
    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            // Flush only retires the state; stored data stays put since nothing reads it while EMPTY.
            if (flush) begin
                state_q <= EMPTY;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            state_q <= ONE;
                            main_q  <= in_ent;
                        end
                    end
                    ONE: begin
                        if (accept && !drain) begin
                            state_q <= TWO;
                            skid_q  <= in_ent;
                        end else if (accept && drain) begin
                            main_q <= in_ent;
                        end else if (drain) begin
                            state_q <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (drain) begin
                            state_q <= ONE;
                            main_q  <= skid_q;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    assign in_ready    = (state_q != TWO);
    assign out_valid   = (state_q != EMPTY);
    assign out_instr   = out_valid ? main_q.instr : BUBBLE_INSTR;
    assign out_pcplus4 = out_valid ? main_q.pcplus4 : '0;
    assign occupancy   = state_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
